// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined Hamming SECDED encoder / checker / corrector.
// Stage 1 registers the word with its syndrome and overall parity, stage 2
// applies the correction and holds the outputs. Saturating error counters
// and a sticky log of the first uncorrectable syndrome sit on the output side.
module ecc_secded_pipe #(
    parameter int DW    = 32,
    parameter int CNT_W = 16,
    // Hamming check-bit count for DW in 8..64, plus one overall parity bit.
    localparam int PW   = ((DW <= 11) ? 4 : (DW <= 26) ? 5 : (DW <= 57) ? 6 : 7) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [PW-1:0]    in_ecc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [PW-1:0]    out_ecc,
    output logic             out_sbe,
    output logic             out_dbe,
    output logic [CNT_W-1:0] sbe_count,
    output logic [CNT_W-1:0] dbe_count,
    output logic             log_valid,
    output logic [PW-1:0]    log_syndrome
);

    localparam int R    = PW - 1;
    localparam int NPOS = DW + R;
    // Highest codeword position; it always fits in R bits.
    localparam logic [R-1:0] LAST_POS = R'(NPOS);

    // Codeword position (1-based) of data bit j: the j-th non-power-of-two.
    function automatic int data_pos(input int j);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p <= NPOS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Check bits of a data word; the top bit makes the whole codeword even.
    function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
        logic [PW-1:0] e;
        e = '0;
        for (int j = 0; j < DW; j++) begin
            int p;
            p = data_pos(j);
            for (int i = 0; i < R; i++) begin
                if (p[i]) e[i] = e[i] ^ d[j];
            end
        end
        e[PW-1] = ^{d, e[R-1:0]};
        return e;
    endfunction

    logic             s1_valid_reg, s1_mode_reg, s1_par_reg;
    logic [DW-1:0]    s1_data_reg;
    logic [PW-1:0]    s1_ecc_reg;
    logic [R-1:0]     s1_syn_reg;
    logic             s2_valid_reg, s2_sbe_reg, s2_dbe_reg;
    logic [DW-1:0]    s2_data_reg;
    logic [PW-1:0]    s2_ecc_reg, s2_log_reg;
    logic [CNT_W-1:0] sbe_cnt_reg, dbe_cnt_reg;
    logic             log_valid_reg;
    logic [PW-1:0]    log_syn_reg;

    logic [PW-1:0]    in_enc;
    logic             s1_load, s2_load, out_fire;
    logic [DW-1:0]    flip_mask, fix_data;
    logic [PW-1:0]    fix_ecc;
    logic [DW-1:0]    s2_data_next;
    logic [PW-1:0]    s2_ecc_next;
    logic             s2_sbe_next, s2_dbe_next;

    assign in_enc   = encode(in_data);
    // A stage loads when empty or when its contents move on this cycle.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;
    assign out_fire = s2_valid_reg && out_ready;

    // One comparator per data bit: set when the syndrome addresses that bit.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_flip
            localparam int POS = data_pos(gi);
            assign flip_mask[gi] = (s1_syn_reg == R'(POS));
        end
    endgenerate

    // Errors confined to check bits leave the data alone; regenerating the
    // check bits from the repaired data fixes those cases too.
    assign fix_data = s1_data_reg ^ flip_mask;
    assign fix_ecc  = encode(fix_data);

    // Stage 1: capture the word with its syndrome and overall parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_data_reg  <= '0;
            s1_ecc_reg   <= '0;
            s1_syn_reg   <= '0;
            s1_par_reg   <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            s1_mode_reg  <= mode;
            s1_data_reg  <= in_data;
            s1_ecc_reg   <= mode ? in_enc : in_ecc;
            s1_syn_reg   <= in_enc[R-1:0] ^ in_ecc[R-1:0];
            s1_par_reg   <= ^{in_data, in_ecc};
        end
    end

    // Stage 2 decision: pass, correct a single error, or flag uncorrectable.
    always_comb begin
        s2_data_next = s1_data_reg;
        s2_ecc_next  = s1_ecc_reg;
        s2_sbe_next  = 1'b0;
        s2_dbe_next  = 1'b0;
        if (!s1_mode_reg) begin
            if (s1_par_reg) begin
                if (s1_syn_reg <= LAST_POS) begin
                    s2_data_next = fix_data;
                    s2_ecc_next  = fix_ecc;
                    s2_sbe_next  = 1'b1;
                end else begin
                    s2_dbe_next  = 1'b1;
                end
            end else if (s1_syn_reg != '0) begin
                s2_dbe_next = 1'b1;
            end
        end
    end

    // Stage 2 register: outputs only change when the stage reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_ecc_reg   <= '0;
            s2_sbe_reg   <= 1'b0;
            s2_dbe_reg   <= 1'b0;
            s2_log_reg   <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= s2_data_next;
            s2_ecc_reg   <= s2_ecc_next;
            s2_sbe_reg   <= s2_sbe_next;
            s2_dbe_reg   <= s2_dbe_next;
            s2_log_reg   <= {s1_par_reg, s1_syn_reg};
        end
    end

    // Saturating counters and sticky first-DBE log; clr overrides counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbe_cnt_reg   <= '0;
            dbe_cnt_reg   <= '0;
            log_valid_reg <= 1'b0;
            log_syn_reg   <= '0;
        end else if (clr) begin
            sbe_cnt_reg   <= '0;
            dbe_cnt_reg   <= '0;
            log_valid_reg <= 1'b0;
            log_syn_reg   <= '0;
        end else if (out_fire) begin
            if (s2_sbe_reg && (sbe_cnt_reg != {CNT_W{1'b1}}))
                sbe_cnt_reg <= sbe_cnt_reg + 1'b1;
            if (s2_dbe_reg && (dbe_cnt_reg != {CNT_W{1'b1}}))
                dbe_cnt_reg <= dbe_cnt_reg + 1'b1;
            if (s2_dbe_reg && !log_valid_reg) begin
                log_valid_reg <= 1'b1;
                log_syn_reg   <= s2_log_reg;
            end
        end
    end

    assign out_valid    = s2_valid_reg;
    assign out_data     = s2_data_reg;
    assign out_ecc      = s2_ecc_reg;
    assign out_sbe      = s2_sbe_reg;
    assign out_dbe      = s2_dbe_reg;
    assign sbe_count    = sbe_cnt_reg;
    assign dbe_count    = dbe_cnt_reg;
    assign log_valid    = log_valid_reg;
    assign log_syndrome = log_syn_reg;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe (DW=32, CNT_W=2) with an output scoreboard.
module tb_ecc_secded_pipe;
    localparam int DW = 32;
    localparam int CNT_W = 2;
    localparam int PW = 7;

    logic clk, rst, clr, mode, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [PW-1:0] in_ecc, out_ecc, log_syndrome;
    logic out_sbe, out_dbe, log_valid;
    logic [CNT_W-1:0] sbe_count, dbe_count;

    ecc_secded_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ecc(in_ecc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ecc(out_ecc),
        .out_sbe(out_sbe), .out_dbe(out_dbe), .sbe_count(sbe_count), .dbe_count(dbe_count),
        .log_valid(log_valid), .log_syndrome(log_syndrome)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [6:0]  e;
        logic        sbe;
        logic        dbe;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference codeword view: bit 0 is overall parity, positions 1..38 Hamming.
    function automatic logic [38:0] pack_cw(input logic [31:0] d, input logic [6:0] e);
        logic [38:0] cw;
        int k, c;
        k = 0;
        c = 0;
        cw[0] = e[6];
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) begin cw[p] = e[c]; c++; end
            else begin cw[p] = d[k]; k++; end
        end
        return cw;
    endfunction

    function automatic logic [38:0] unpack_cw(input logic [38:0] cw);
        logic [31:0] d;
        logic [6:0] e;
        int k, c;
        k = 0;
        c = 0;
        e[6] = cw[0];
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) begin e[c] = cw[p]; c++; end
            else begin d[k] = cw[p]; k++; end
        end
        return {d, e};
    endfunction

    function automatic logic [6:0] model_enc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0] e;
        logic b;
        cw = pack_cw(d, 7'h0);
        e = '0;
        for (int i = 0; i < 6; i++) begin
            b = 1'b0;
            for (int p = 1; p <= 38; p++) if (((p >> i) & 1) == 1) b = b ^ cw[p];
            e[i] = b;
        end
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    // Flip one codeword position of a {data, ecc} pair.
    function automatic logic [38:0] flip(input logic [38:0] de, input int p);
        logic [38:0] cw;
        cw = pack_cw(de[38:7], de[6:0]);
        cw[p] = ~cw[p];
        return unpack_cw(cw);
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [6:0] e, input logic s, input logic b);
        exp_t x;
        x.d = d; x.e = e; x.sbe = s; x.dbe = b;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; the expected output is queued at the accepting edge.
    task automatic send(input logic [31:0] d, input logic [6:0] e, input logic m, input exp_t x);
        int n;
        in_data = d; in_ecc = e; mode = m; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        else sbq.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        #1;
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    logic held = 1'b0;
    logic [41:0] held_v;
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                chk("hold_stable", 64'({out_valid, out_data, out_ecc, out_sbe, out_dbe}), 64'(held_v));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_word", {63'd0, out_valid}, 64'd0);
                end else begin
                    x = sbq.pop_front();
                    chk("out_data", 64'(out_data), 64'(x.d));
                    chk("out_ecc", 64'(out_ecc), 64'(x.e));
                    chk("out_flags", 64'({out_sbe, out_dbe}), 64'({x.sbe, x.dbe}));
                end
            end
            held = out_valid && !out_ready;
            held_v = {out_valid, out_data, out_ecc, out_sbe, out_dbe};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [6:0] we;
        logic [38:0] c;
        int t0;
        rst = 1'b1; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ecc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_counts", 64'({sbe_count, dbe_count}), 64'd0);
        chk("rst_log", 64'({log_valid, log_syndrome}), 64'd0);
        chk("rst_out_data", 64'({out_data, out_ecc, out_sbe, out_dbe}), 64'd0);
        rst = 1'b0;
        step();

        // Encode-only with known check bits; garbage in_ecc must be ignored.
        send(32'h0000_0000, 7'h55, 1'b1, mk(32'h0000_0000, 7'h00, 1'b0, 1'b0));
        @(negedge clk);
        chk("latency_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("latency_c2", {63'd0, out_valid}, 64'd1);
        step();
        send(32'hFFFF_FFFF, 7'h2A, 1'b1, mk(32'hFFFF_FFFF, 7'h18, 1'b0, 1'b0));
        drain();
        chk("enc_no_count", 64'({sbe_count, dbe_count}), 64'd0);

        // Single-bit correction on DEADBEEF: data bit, parity bit, last data bit.
        w = 32'hDEAD_BEEF;
        we = model_enc(w);
        send(w, 7'h00, 1'b1, mk(w, we, 1'b0, 1'b0));
        send(w, we, 1'b0, mk(w, we, 1'b0, 1'b0));
        drain();
        chk("clean_no_count", 64'(sbe_count), 64'd0);
        c = flip({w, we}, 9);
        send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
        drain();
        chk("sbe_cnt_bit9", 64'(sbe_count), 64'd1);
        c = flip({w, we}, 0);
        send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
        drain();
        chk("sbe_cnt_bit0", 64'(sbe_count), 64'd2);
        c = flip({w, we}, 38);
        send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
        drain();
        chk("sbe_cnt_bit38", 64'(sbe_count), 64'd3);

        // Double errors and the sticky log.
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_counts", 64'({sbe_count, dbe_count}), 64'd0);
        c = flip(flip({w, we}, 3), 24);
        send(c[38:7], c[6:0], 1'b0, mk(c[38:7], c[6:0], 1'b0, 1'b1));
        drain();
        chk("dbe_cnt1", 64'(dbe_count), 64'd1);
        chk("log_first", 64'({log_valid, log_syndrome}), 64'({1'b1, 7'd27}));
        c = flip(flip({w, we}, 1), 2);
        send(c[38:7], c[6:0], 1'b0, mk(c[38:7], c[6:0], 1'b0, 1'b1));
        drain();
        chk("dbe_cnt2", 64'(dbe_count), 64'd2);
        chk("log_sticky", 64'({log_valid, log_syndrome}), 64'({1'b1, 7'd27}));
        // Odd parity but syndrome 49 points past the codeword: uncorrectable.
        c = flip(flip(flip({w, we}, 32), 16), 1);
        send(c[38:7], c[6:0], 1'b0, mk(c[38:7], c[6:0], 1'b0, 1'b1));
        drain();
        chk("dbe_beyond", 64'({sbe_count, dbe_count}), 64'({2'd0, 2'd3}));
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_log", 64'({log_valid, log_syndrome, dbe_count}), 64'd0);

        // Full throughput: eight words in eight cycles.
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            we = model_enc(w);
            send(w, we, 1'b0, mk(w, we, 1'b0, 1'b0));
        end
        chk("throughput_cycles", 64'(cyc - t0), 64'd8);
        drain();

        // Backpressure 1,0,0 repeating with a mix of clean and corrected words.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    out_ready = (i % 3 == 0);
                    step();
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    w = $urandom;
                    we = model_enc(w);
                    if (i % 2 == 1) begin
                        c = flip({w, we}, i * 4 + 1);
                        send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
                    end else begin
                        send(w, we, 1'b0, mk(w, we, 1'b0, 1'b0));
                    end
                end
            end
        join
        drain();

        // Counter saturation at CNT_W=2, then clr racing a counting handshake.
        clr = 1'b1; step(); clr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w = 32'h1234_0000 + 32'(k);
            we = model_enc(w);
            c = flip({w, we}, k * 5);
            send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
            drain();
            chk("sbe_sat", 64'(sbe_count), 64'((k > 3) ? 3 : k));
        end
        out_ready = 1'b0;
        w = 32'hCAFE_F00D;
        we = model_enc(w);
        c = flip({w, we}, 20);
        send(c[38:7], c[6:0], 1'b0, mk(w, we, 1'b1, 1'b0));
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("fifth_ready", {63'd0, out_valid}, 64'd1);
        step();
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_wins", 64'(sbe_count), 64'd0);
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(32'hAAAA_0001, model_enc(32'hAAAA_0001), 1'b0, mk(32'hAAAA_0001, model_enc(32'hAAAA_0001), 1'b0, 1'b0));
        send(32'hAAAA_0002, model_enc(32'hAAAA_0002), 1'b0, mk(32'hAAAA_0002, model_enc(32'hAAAA_0002), 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        sbq.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("no_stale", {63'd0, out_valid}, 64'd0);
        w = 32'h5555_0003;
        we = model_enc(w);
        send(w, we, 1'b0, mk(w, we, 1'b0, 1'b0));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
